// File: rtl/mem_responder.sv
// mem_responder: word-array memory model for the multicycle RV32I memory port.
// A request is accepted in IDLE and its address, data, lanes and op are latched.
// After LATENCY cycles a one-cycle mem_resp is issued. Reads return data in that
// cycle. Writes commit on the edge that ends the response cycle.
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;

    // Request fields captured at acceptance
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic                  r_is_write;
    logic                  r_err;

    logic [31:0]           r_mem [DEPTH];
    logic [31:0]           r_rdata;

    logic                  w_req;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_in_idx;
    logic                  w_in_err;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic                  w_cur_is_write;
    logic                  w_cur_err;
    logic                  w_load_rdata;
    logic                  w_commit;
    logic                  w_unused_addr_lsb;

    assign w_req    = mem_read | mem_write;
    assign w_accept = (r_state == IDLE) && w_req;
    assign w_in_idx = mem_address[ADDR_WIDTH+1:2];
    // Out-of-range address or both strobes at once are rejected with mem_err
    assign w_in_err = (|mem_address[31:ADDR_WIDTH+2]) | (mem_read & mem_write);

    // Byte-offset bits carry no meaning for a word-wide array
    assign w_unused_addr_lsb = ^mem_address[1:0];

    // With LATENCY=1 the response is entered straight from IDLE, so the read
    // side must look at the live request rather than the latched copy.
    assign w_rd_idx       = (r_state == IDLE) ? w_in_idx  : r_idx;
    assign w_cur_is_write = (r_state == IDLE) ? mem_write : r_is_write;
    assign w_cur_err      = (r_state == IDLE) ? w_in_err  : r_err;

    assign w_load_rdata = (w_state_nxt == RESP) && (r_state != RESP)
                          && !w_cur_is_write && !w_cur_err;
    assign w_commit     = (r_state == RESP) && r_is_write && !r_err;

    assign mem_resp  = (r_state == RESP);
    assign mem_err   = (r_state == RESP) && r_err;
    assign mem_rdata = r_rdata;

    // State and latency counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept, count down, abort on dropped strobes, respond
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = RESP;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (!w_req) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Latch the request fields when a request is accepted
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx      <= w_in_idx;
            r_wdata    <= mem_wdata;
            r_be       <= mem_byte_enable;
            r_is_write <= mem_write;
            r_err      <= w_in_err;
        end
    end

    // Read data register: loaded on entry to the response cycle of a good read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (w_load_rdata) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    // Array write on the edge ending the response; reset discards it
    always_ff @(posedge clk) begin
        if (!rst && w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=3, one at LATENCY=1.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        rd3 = 1'b0, wr3 = 1'b0;
    logic [3:0]  be3 = 4'h0;
    logic [31:0] addr3 = 32'h0, wd3 = 32'h0;
    logic [31:0] rdata3;
    logic        resp3, err3;

    logic        rd1 = 1'b0, wr1 = 1'b0;
    logic [3:0]  be1 = 4'h0;
    logic [31:0] addr1 = 32'h0, wd1 = 32'h0;
    logic [31:0] rdata1;
    logic        resp1, err1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut (
        .clk(clk), .rst(rst),
        .mem_read(rd3), .mem_write(wr3), .mem_byte_enable(be3),
        .mem_address(addr3), .mem_wdata(wd3),
        .mem_rdata(rdata3), .mem_resp(resp3), .mem_err(err3)
    );

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .mem_read(rd1), .mem_write(wr1), .mem_byte_enable(be1),
        .mem_address(addr1), .mem_wdata(wd1),
        .mem_rdata(rdata1), .mem_resp(resp1), .mem_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction on the LATENCY=3 instance. lat is the number of rising
    // edges from the first sampling edge up to the one opening the response
    // cycle (0 on timeout); resp_after is mem_resp one cycle later.
    task automatic txn3(input logic rd, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output logic resp_after);
        @(negedge clk);
        rd3 = rd; wr3 = wr; be3 = be; addr3 = addr; wd3 = wd;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (resp3) begin
                lat = i;
                break;
            end
        end
        rdata = rdata3;
        err   = err3;
        rd3 = 1'b0; wr3 = 1'b0;
        @(posedge clk); #1;
        resp_after = resp3;
    endtask

    task automatic write3(input string tag, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be);
        int          lat;
        logic [31:0] rd;
        logic        err, ra;
        txn3(1'b0, 1'b1, be, addr, wd, lat, rd, err, ra);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_err"}, err, 0);
        check({tag, "_1cyc"}, ra, 0);
    endtask

    task automatic read3(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp);
        int          lat;
        logic [31:0] rd;
        logic        err, ra;
        txn3(1'b1, 1'b0, 4'h0, addr, 32'h0, lat, rd, err, ra);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, err, 0);
        check({tag, "_1cyc"}, ra, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat, cnt;
        logic [31:0] rd;
        logic        err, ra, prev;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp", resp3, 0);
        check("rst_err", err3, 0);
        check("rst_rdata", rdata3, 32'h0);
        check("rst_resp1", resp1, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read
        write3("wr_beef", 32'h10, 32'hDEADBEEF, 4'hF);
        read3("rd_beef", 32'h10, 32'hDEADBEEF);

        // Byte lanes
        write3("wr_pre20", 32'h20, 32'h11223344, 4'hF);
        write3("wr_be0101", 32'h20, 32'hAABBCCDD, 4'b0101);
        read3("rd_lanes", 32'h20, 32'h11BB33DD);
        write3("wr_be0000", 32'h20, 32'hFFFFFFFF, 4'b0000);
        read3("rd_be0000", 32'h20, 32'h11BB33DD);

        // Low address bits ignored
        read3("rd_0x23", 32'h23, 32'h11BB33DD);

        // Out of range address
        txn3(1'b1, 1'b0, 4'h0, 32'h1000, 32'h0, lat, rd, err, ra);
        check("oor_lat", lat, 3);
        check("oor_err", err, 1);
        check("oor_rdata_kept", rd, 32'h11BB33DD);

        // Read and write together
        write3("wr_pre40", 32'h40, 32'h12345678, 4'hF);
        txn3(1'b1, 1'b1, 4'hF, 32'h40, 32'h5, lat, rd, err, ra);
        check("both_lat", lat, 3);
        check("both_err", err, 1);
        check("both_rdata_kept", rd, 32'h11BB33DD);
        read3("rd_40_old", 32'h40, 32'h12345678);

        // Abort: strobe dropped during BUSY
        @(negedge clk);
        rd3 = 1'b1; addr3 = 32'h10;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rd3 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp3) cnt++;
        end
        check("abort_no_resp", cnt, 0);
        read3("rd_after_abort", 32'h10, 32'hDEADBEEF);

        // Reset during a write
        write3("wr_pre30", 32'h30, 32'h0, 4'hF);
        read3("rd_beef2", 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        wr3 = 1'b1; be3 = 4'hF; addr3 = 32'h30; wd3 = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; wr3 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp3) cnt++;
        end
        check("rstmid_no_resp", cnt, 0);
        check("rstmid_rdata0", rdata3, 32'h0);
        read3("rd_30_after_rst", 32'h30, 32'h0);

        // LATENCY=1: single write, then mem_read held across transactions
        @(negedge clk);
        wr1 = 1'b1; be1 = 4'hF; addr1 = 32'h4; wd1 = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("l1_wr_resp", resp1, 1);
        check("l1_wr_err", err1, 0);
        wr1 = 1'b0;
        @(posedge clk); #1;
        check("l1_wr_1cyc", resp1, 0);
        @(negedge clk);
        rd1 = 1'b1; addr1 = 32'h4;
        prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("l1_pat%0d", i), resp1, (i % 2 == 0) ? 1 : 0);
            if (resp1) begin
                check($sformatf("l1_data%0d", i), rdata1, 32'hCAFEF00D);
                check($sformatf("l1_err%0d", i), err1, 0);
            end
            check($sformatf("l1_noconsec%0d", i), resp1 & prev, 0);
            prev = resp1;
        end
        @(negedge clk);
        rd1 = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle RV32I core's memory port.
- Accepts read and write requests from the datapath/control pair: word-aligned address, write data, byte enables, read/write strobes.
- Services each request from an internal word array after a programmable latency, then returns a single-cycle mem_resp.
- Used as the behavioural/synthesizable memory for core bring-up, and as the target model for protocol checking.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; the array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- mem_read  input  1  read request strobe; held high by the requester until mem_resp.
- mem_write  input  1  write request strobe; held high by the requester until mem_resp.
- mem_byte_enable  input  4  write lane mask; bit i enables byte lane i (bits 8i+7:8i).
- mem_address  input  32  byte address; bits 1:0 are ignored.
- mem_wdata  input  32  write data, already lane-shifted by the requester.
- mem_rdata  output  32  read data; valid in the mem_resp cycle of a read.
- mem_resp  output  1  single-cycle completion pulse.
- mem_err  output  1  high together with mem_resp when the transaction is rejected.

Behaviour:
- Reset: on rst high at a clock edge, state becomes IDLE, the counter is cleared, and mem_rdata, mem_resp and mem_err go to 0. Array contents are not cleared. A transaction in flight is discarded: no write occurs and no mem_resp is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE -> BUSY: taken when (mem_read | mem_write) is high at an edge. The responder latches the address word index, wdata, byte_enable and the op at that edge, and loads the counter with LATENCY-1.
- BUSY: the counter decrements each cycle. When the counter is 0, the next state is RESP. With LATENCY=1, BUSY lasts zero cycles: IDLE goes directly to RESP.
- Latency: a request first sampled high at edge t produces mem_resp high during the cycle following edge t+LATENCY-1, i.e. LATENCY cycles after the request is first visible.
- RESP: mem_resp=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
  - Read: mem_rdata = array[idx] is driven during the RESP cycle.
  - Write: the array is updated on the edge ending RESP, lane by lane per the latched byte_enable. byte_enable=0000 still completes with no array change.
- mem_rdata holds its last read value until the next successful read's RESP. Writes and errors leave it unchanged.
- Back-to-back requests: the requester must drop its strobes in the cycle after mem_resp. Any strobe seen in IDLE is treated as a new request, including the cycle immediately after RESP. Minimum spacing between mem_resp pulses is LATENCY+1 cycles.
- Abort: if both strobes are low during BUSY, the FSM returns to IDLE on the next edge with no write and no mem_resp.
- Inputs changing during BUSY are ignored (values are latched at acceptance), except for the abort check.
- Errors, reported as mem_resp=1 with mem_err=1 at normal latency, with no array write and mem_rdata unchanged:
  - mem_address[31:ADDR_WIDTH+2] nonzero (out of range);
  - mem_read and mem_write both high at acceptance.
- mem_err is 0 whenever mem_resp is 0.
- The word index is mem_address[ADDR_WIDTH+1:2], so there is no wrap-around inside the array.

Test Plan:
- LATENCY=3: write 0xDEADBEEF to 0x00000010 with be=1111, then read 0x00000010 -> each mem_resp arrives 3 cycles after its strobe rises and lasts 1 cycle; the read returns 0xDEADBEEF with mem_err=0.
- Byte lanes: preload 0x11223344 at 0x20; write wdata 0xAABBCCDD with be=0101; read 0x20 -> 0x11BB33DD. Repeat with be=0000 -> read returns 0x11BB33DD and the write still gets mem_resp.
- Address low bits ignored: read 0x00000023 after the previous step -> 0x11BB33DD. Read 0x00001000 with ADDR_WIDTH=10 -> mem_resp=1, mem_err=1, mem_rdata keeps its previous value.
- Protocol errors: assert read and write together at 0x40 with wdata 0x5 -> mem_err=1 and a later read of 0x40 returns the old value. Drop mem_read after 1 BUSY cycle -> no mem_resp and the FSM is back in IDLE 1 cycle later.
- Reset mid-write: start a write of 0xFFFFFFFF to 0x30 (old value 0x0), pulse rst during BUSY -> no mem_resp, mem_rdata=0, and a later read of 0x30 returns 0x0.
- LATENCY=1 back-to-back: hold mem_read across two transactions -> mem_resp is high in alternate cycles (every 2nd cycle) and never on consecutive cycles.
